reset_seq: RTL and testbench
============================

RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 Parameter SYNC_STAGES, default 2, sets synchroniser depth on RST_n; legal range >=2.
REQ-002 Parameter NCH, default 3, sets number of sequenced reset outputs; legal range 1..8.
REQ-003 Parameter FILT, default 16, sets consecutive synchronised-high cycles of RST_n required before release; legal range >=1.
REQ-004 Parameter GAP, default 4, sets cycles between successive channel releases; legal range >=1.
REQ-005 clk  input  1  system clock; all flops update on rising edge only.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 RST_n  input  1  external reset request, asynchronous to clk, active-low (pushbutton/supervisor).
REQ-008 rst_n  output  NCH  sequenced active-low resets; bit k feeds domain k; all bits registered.
REQ-009 seq_done  output  1  high when every rst_n bit is deasserted; registered.

Function
REQ-010 RST_n SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is req_s, and no other logic samples RST_n.
REQ-011 FSM states SHALL be HOLD, RELEASE, DONE.
REQ-012 HOLD: rst_n all 0, seq_done 0; filter counter increments on each edge with req_s=1 and clears to 0 on any edge with req_s=0.
REQ-013 HOLD->RELEASE on the edge where req_s=1 and filter count==FILT-1; rst_n[0] SHALL go 1 on that same edge.
REQ-014 RELEASE: gap counter counts edges; rst_n[k] SHALL go 1 exactly k*GAP edges after rst_n[0]; released bits stay 1.
REQ-015 RELEASE->DONE on the edge rst_n[NCH-1] goes 1; seq_done SHALL go 1 on that same edge.
REQ-016 NCH=1: rst_n[0] and seq_done SHALL rise on the same edge, with the FSM going HOLD->DONE directly.
REQ-017 Any edge in RELEASE or DONE with req_s=0 SHALL move to HOLD, drive all rst_n to 0 and seq_done to 0 on that edge, and clear both counters.
REQ-018 Assertion latency: the RST_n falling edge SHALL be seen at rst_n within SYNC_STAGES+1 edges; even a one-cycle low pulse captured by the chain SHALL restart the full sequence.
REQ-019 Counter widths SHALL be $clog2-sized for FILT and GAP; counters SHALL saturate and never wrap in any state.
REQ-020 rst_n bits SHALL only change together (assert) or in ascending index order (deassert); no output glitches, because every output comes directly from a flop.

Reset
REQ-021 rst=1 at an edge SHALL clear the synchroniser chain to 0, set state HOLD, clear both counters, drive rst_n=0 and seq_done=0; rst overrides all other inputs.
REQ-022 rst asserted mid-RELEASE or in DONE SHALL behave identically to REQ-021; after rst drops, the sequence SHALL restart from HOLD with filter count 0.

Configuration
REQ-023 Macro RST_SEQ_SWREQ_EN defined: add port sw_rst  input  1, a synchronous software reset request. sw_rst=1 at any edge acts as req_s=0 per REQ-012/REQ-017 and bypasses the synchroniser, so rst_n drops on that edge.
REQ-024 Macro RST_SEQ_SWREQ_EN undefined: sw_rst port and its logic SHALL be absent; behaviour per REQ-010..REQ-022 only.

Verification (defaults SYNC_STAGES=2, FILT=16, GAP=4, NCH=3)
REQ-025 rst=1 for 3 edges, RST_n=1 -> rst_n=3'b000 and seq_done=0 throughout; after rst drops, sequence per REQ-026.
REQ-026 RST_n=1 first captured at edge 1 -> rst_n[0]=1 at edge 18, rst_n[1]=1 at edge 22, rst_n[2]=1 and seq_done=1 at edge 26.
REQ-027 In HOLD, RST_n low for 1 cycle after 10 good edges -> filter count clears; rst_n[0] rises 16 edges after req_s returns high.
REQ-028 In DONE, one-cycle RST_n low pulse -> rst_n=000 and seq_done=0 within 3 edges, then full re-release 16/20/24 edges after req_s returns high.
REQ-029 rst=1 between edges 18 and 22 -> rst_n=000 next edge; bits 1 and 2 never rise before a fresh 16-edge filter completes.
REQ-030 With RST_SEQ_SWREQ_EN, sw_rst=1 for one edge in DONE -> rst_n=000 on that edge, re-release 16/20/24 edges later; without the macro, the build has no sw_rst port.

Source files
------------

// File: rtl/reset_seq.sv
// Reset sequencer: synchronises RST_n, filters it, then releases NCH reset domains in order.
// Optional build macro RST_SEQ_SWREQ_EN adds the sw_rst software reset request input.
module reset_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int NCH         = 3,
  parameter int FILT        = 16,
  parameter int GAP         = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           RST_n,
`ifdef RST_SEQ_SWREQ_EN
  input  logic           sw_rst,
`endif
  output logic [NCH-1:0] rst_n,
  output logic           seq_done
);

  localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [FW-1:0] FILT_MAX = FW'(FILT - 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          filt_q, filt_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [CW-1:0]          ch_q, ch_d;
  logic [CW-1:0]          ch_nxt;
  logic [NCH-1:0]         rst_n_q, rst_n_d;
  logic                   done_q, done_d;
  logic                   req_s;
  logic                   req_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], RST_n};
    end
  end

  assign req_s = sync_q[SYNC_STAGES-1];

`ifdef RST_SEQ_SWREQ_EN
  // Software request skips the synchroniser so outputs drop on the requesting edge.
  assign req_ok = req_s & ~sw_rst;
`else
  assign req_ok = req_s;
`endif

  assign ch_nxt = ch_q + 1'b1;

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    gap_d   = gap_q;
    ch_d    = ch_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;

    case (state_q)
      HOLD: begin
        rst_n_d = '0;
        done_d  = 1'b0;
        gap_d   = '0;
        ch_d    = '0;
        if (!req_ok) begin
          filt_d = '0;
        end else if (filt_q == FILT_MAX) begin
          filt_d     = '0;
          rst_n_d[0] = 1'b1;
          if (NCH == 1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          filt_d = filt_q + 1'b1;
        end
      end

      RELEASE: begin
        if (!req_ok) begin
          state_d = HOLD;
          filt_d  = '0;
          gap_d   = '0;
          ch_d    = '0;
          rst_n_d = '0;
          done_d  = 1'b0;
        end else if (gap_q == GAP_MAX) begin
          gap_d = '0;
          ch_d  = ch_nxt;
          for (int unsigned k = 0; k < NCH; k++) begin
            if (CW'(k) == ch_nxt) rst_n_d[k] = 1'b1;
          end
          if (ch_nxt == CH_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      DONE: begin
        if (!req_ok) begin
          state_d = HOLD;
          filt_d  = '0;
          gap_d   = '0;
          ch_d    = '0;
          rst_n_d = '0;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = HOLD;
        filt_d  = '0;
        gap_d   = '0;
        ch_d    = '0;
        rst_n_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      filt_q  <= '0;
      gap_q   <= '0;
      ch_q    <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      gap_q   <= gap_d;
      ch_q    <= ch_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  assign rst_n    = rst_n_q;
  assign seq_done = done_q;

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq at default parameters; expected {seq_done, rst_n} per edge are queued then popped.
module tb_reset_seq;

  localparam int NCH = 3;
  localparam int GAP = 4;

  typedef struct {
    logic [NCH-1:0] r;
    logic           d;
    string          name;
    int             edge_no;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           RST_n = 1'b1;
`ifdef RST_SEQ_SWREQ_EN
  logic           sw_rst = 1'b0;
`endif
  logic [NCH-1:0] rst_n;
  logic           seq_done;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  reset_seq #(
    .SYNC_STAGES(2),
    .NCH        (NCH),
    .FILT       (16),
    .GAP        (GAP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .RST_n   (RST_n),
`ifdef RST_SEQ_SWREQ_EN
    .sw_rst  (sw_rst),
`endif
    .rst_n   (rst_n),
    .seq_done(seq_done)
  );

  // Expected outputs at edge t when rst_n[0] is released at edge r0.
  function automatic exp_t exp_at(int t, int r0, string name);
    exp_t e;
    for (int k = 0; k < NCH; k++) e.r[k] = (t >= r0 + k * GAP);
    e.d       = (t >= r0 + (NCH - 1) * GAP);
    e.name    = name;
    e.edge_no = t;
    return e;
  endfunction

  function automatic exp_t exp_const(logic [NCH-1:0] r, logic d, int t, string name);
    exp_t e;
    e.r       = r;
    e.d       = d;
    e.name    = name;
    e.edge_no = t;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) sb.push_back(exp_const('0, 1'b0, i, "reset"));
    for (int i = 0; i < 3; i++) begin
      rst   = 1'b1;
      RST_n = 1'b1;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({seq_done, rst_n} !== {e.d, e.r}) begin
        errors++;
        $display("FAIL %s edge %0d: got done=%b rst_n=%b, want done=%b rst_n=%b",
                 e.name, e.edge_no, seq_done, rst_n, e.d, e.r);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sequence();
    exp_t e;
    rst = 1'b0;
    for (int i = 1; i <= 30; i++) sb.push_back(exp_at(i, 18, "sequence"));
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({seq_done, rst_n} !== {e.d, e.r}) begin
        errors++;
        $display("FAIL %s edge %0d: got done=%b rst_n=%b, want done=%b rst_n=%b",
                 e.name, e.edge_no, seq_done, rst_n, e.d, e.r);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_filter_glitch();
    exp_t e;
    sb.push_back(exp_const('0, 1'b0, 0, "glitch_rst"));
    for (int i = 1; i <= 40; i++) sb.push_back(exp_at(i, 29, "filter_glitch"));
    for (int i = 0; i <= 40; i++) begin
      rst   = (i == 0);
      RST_n = (i != 11);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({seq_done, rst_n} !== {e.d, e.r}) begin
        errors++;
        $display("FAIL %s edge %0d: got done=%b rst_n=%b, want done=%b rst_n=%b",
                 e.name, e.edge_no, seq_done, rst_n, e.d, e.r);
      end
      @(negedge clk);
    end
    RST_n = 1'b1;
  endtask

  task automatic test_done_pulse();
    exp_t e;
    for (int i = 1; i <= 30; i++) begin
      if (i < 3) sb.push_back(exp_const('1, 1'b1, i, "done_pulse"));
      else       sb.push_back(exp_at(i, 19, "done_pulse"));
    end
    for (int i = 1; i <= 30; i++) begin
      RST_n = (i != 1);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({seq_done, rst_n} !== {e.d, e.r}) begin
        errors++;
        $display("FAIL %s edge %0d: got done=%b rst_n=%b, want done=%b rst_n=%b",
                 e.name, e.edge_no, seq_done, rst_n, e.d, e.r);
      end
      @(negedge clk);
    end
    RST_n = 1'b1;
  endtask

  task automatic test_rst_mid();
    exp_t e;
    sb.push_back(exp_const('0, 1'b0, 0, "rst_mid_init"));
    for (int i = 1; i <= 50; i++) begin
      if (i < 20) sb.push_back(exp_at(i, 18, "rst_mid"));
      else        sb.push_back(exp_at(i, 38, "rst_mid"));
    end
    for (int i = 0; i <= 50; i++) begin
      rst = (i == 0) || (i == 20);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({seq_done, rst_n} !== {e.d, e.r}) begin
        errors++;
        $display("FAIL %s edge %0d: got done=%b rst_n=%b, want done=%b rst_n=%b",
                 e.name, e.edge_no, seq_done, rst_n, e.d, e.r);
      end
      @(negedge clk);
    end
    rst = 1'b0;
  endtask

`ifdef RST_SEQ_SWREQ_EN
  task automatic test_swreq();
    exp_t e;
    for (int i = 1; i <= 30; i++) sb.push_back(exp_at(i, 17, "swreq"));
    for (int i = 1; i <= 30; i++) begin
      sw_rst = (i == 1);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      checks++;
      if ({seq_done, rst_n} !== {e.d, e.r}) begin
        errors++;
        $display("FAIL %s edge %0d: got done=%b rst_n=%b, want done=%b rst_n=%b",
                 e.name, e.edge_no, seq_done, rst_n, e.d, e.r);
      end
      @(negedge clk);
    end
    sw_rst = 1'b0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequence();
    test_filter_glitch();
    test_done_pulse();
    test_rst_mid();
`ifdef RST_SEQ_SWREQ_EN
    test_swreq();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
